// File: rtl/bgraph_encoder.sv
// bgraph_encoder
//   Recovers a 4-bit thermometer code plus turbo (upper-half) flag from an
//   asynchronous 8-segment bar-graph pattern. The pattern is double-flop
//   synchronized, then must hold for STABLE_CYCLES identical samples before
//   it is accepted. Non-thermometer patterns raise Err_out and bump a
//   saturating error counter while leaving Thermo_out/Turbo_out unchanged.
//
// Ports
//   Clk_in      in   1  system clock, rising edge
//   Reset_in    in   1  async active-high reset
//   BGraph_in   in   8  raw bar-graph pattern (async), bit 0 = lowest segment
//   Thermo_out  out  4  accepted thermometer code, LSB-filled
//   Turbo_out   out  1  accepted level is 5..8 segments
//   Err_out     out  1  last accepted pattern was illegal
//   Upd_out     out  1  one-cycle pulse per accepted change
//   ErrCnt_out  out  8  illegal patterns accepted, saturates at 255
module bgraph_encoder #(
  parameter int STABLE_CYCLES = 4  // legal 2..255
) (
  input  logic       Clk_in,
  input  logic       Reset_in,
  input  logic [7:0] BGraph_in,
  output logic [3:0] Thermo_out,
  output logic       Turbo_out,
  output logic       Err_out,
  output logic       Upd_out,
  output logic [7:0] ErrCnt_out
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  // LOCKED is registered as "cnt already at CNT_MAX"; acceptance additionally
  // needs the current synchronized sample to still match the candidate.
  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [7:0] sync1, s;
  logic [7:0] cand, cand_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] com;
  logic       accept, new_chg, legal;

  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      sync1   <= '0;
      s       <= '0;
      cand    <= '0;
      cnt     <= '0;
      state_q <= SETTLE;
    end else begin
      sync1   <= BGraph_in;
      s       <= sync1;
      cand    <= cand_d;
      cnt     <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    cand_d = cand;
    cnt_d  = cnt;
    accept = 1'b0;
    case (state_q)
      SETTLE: begin
        if (s != cand) begin
          cand_d = s;
          cnt_d  = 8'd1;
        end else if (cnt < CNT_MAX) begin
          cnt_d  = cnt + 8'd1;
        end
      end
      LOCKED: begin
        if (s != cand) begin
          cand_d = s;
          cnt_d  = 8'd1;
        end else begin
          accept = 1'b1;
        end
      end
      default: ;
    endcase
    // With STABLE_CYCLES=2 a fresh load already reaches CNT_MAX.
    state_d = (cnt_d == CNT_MAX) ? LOCKED : SETTLE;
  end

  // Re-accepting the committed pattern (e.g. after a rejected glitch) is silent.
  assign new_chg = accept && (cand != com);

  // Thermometer iff ones are contiguous from bit 0: x & (x+1) == 0 (0xFF wraps).
  assign legal = ((cand & (cand + 8'd1)) == 8'd0);

  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      com        <= '0;
      Thermo_out <= '0;
      Turbo_out  <= 1'b0;
      Err_out    <= 1'b0;
      Upd_out    <= 1'b0;
      ErrCnt_out <= '0;
    end else begin
      Upd_out <= new_chg;
      if (new_chg) begin
        com <= cand;
        if (legal) begin
          // For a legal code bit 4 marks the upper half; the remaining fill
          // is then exactly the upper or lower nibble.
          Turbo_out  <= cand[4];
          Thermo_out <= cand[4] ? cand[7:4] : cand[3:0];
          Err_out    <= 1'b0;
        end else begin
          Err_out <= 1'b1;
          if (ErrCnt_out != 8'hFF) ErrCnt_out <= ErrCnt_out + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bgraph_encoder.sv
module tb_bgraph_encoder;
  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bg;
  logic [3:0] thermo;
  logic       turbo, err, upd;
  logic [7:0] errcnt;

  int vectors = 0;
  int miscompares = 0;
  int upd_cnt = 0;
  bit auto_en = 1'b0;

  bgraph_encoder #(.STABLE_CYCLES(STABLE)) dut (
    .Clk_in(clk), .Reset_in(rst), .BGraph_in(bg),
    .Thermo_out(thermo), .Turbo_out(turbo), .Err_out(err),
    .Upd_out(upd), .ErrCnt_out(errcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks how many consecutive edges the synchronized value
  // has been the same, and accepts once that run reaches STABLE.
  logic [7:0] m_sync1, m_s, m_prev, m_com, m_errcnt;
  logic [3:0] m_thermo;
  logic       m_turbo, m_err, m_upd;
  int         m_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync1 = 0; m_s = 0; m_prev = 0; m_run = 0; m_com = 0;
      m_thermo = 0; m_turbo = 0; m_err = 0; m_upd = 0; m_errcnt = 0;
    end else begin
      logic [7:0] s_now;
      int c;
      s_now   = m_s;
      m_s     = m_sync1;
      m_sync1 = bg;
      if (s_now == m_prev) begin
        if (m_run < STABLE) m_run++;
      end else begin
        m_run  = 1;
        m_prev = s_now;
      end
      m_upd = 0;
      if (m_run >= STABLE && s_now != m_com) begin
        m_upd = 1;
        m_com = s_now;
        c = -1;
        for (int k = 0; k <= 8; k++)
          if (int'(s_now) == (1 << k) - 1) c = k;
        if (c >= 0) begin
          m_err    = 0;
          m_turbo  = (c > 4);
          m_thermo = (c <= 4) ? 4'((1 << c) - 1) : 4'((1 << (c - 4)) - 1);
        end else begin
          m_err = 1;
          if (m_errcnt != 8'd255) m_errcnt = m_errcnt + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && upd) upd_cnt++;
    if (!rst && auto_en) begin
      chk("thermo", thermo, m_thermo);
      chk("turbo", turbo, m_turbo);
      chk("err", err, m_err);
      chk("upd", upd, m_upd);
      chk("errcnt", errcnt, m_errcnt);
    end
  end

  task automatic hold(input logic [7:0] pat, input int n);
    bg = pat;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bg  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_thermo", thermo, 0);
    chk("rst_turbo", turbo, 0);
    chk("rst_err", err, 0);
    chk("rst_upd", upd, 0);
    chk("rst_errcnt", errcnt, 0);
    rst = 1'b0;
    auto_en = 1'b1;

    upd_cnt = 0;
    hold(8'h00, 20);
    chk("idle_no_upd", upd_cnt, 0);

    // Latency: outputs move after edge 6.
    hold(8'h07, 5);
    chk("lat_pre", thermo, 4'b0000);
    @(negedge clk);
    chk("lat_thermo", thermo, 4'b0111);
    chk("lat_turbo", turbo, 0);
    chk("lat_upd", upd, 1);
    @(negedge clk);
    chk("lat_upd_drop", upd, 0);
    hold(8'h07, 4);
    hold(8'h3F, 10);
    chk("p3f_thermo", thermo, 4'b0011);
    chk("p3f_turbo", turbo, 1);
    hold(8'hFF, 10);
    chk("pff_thermo", thermo, 4'b1111);
    chk("pff_turbo", turbo, 1);

    // Glitch rejection.
    hold(8'h0F, 10);
    upd_cnt = 0;
    hold(8'hFF, 2);
    hold(8'h0F, 12);
    chk("glitch_no_upd", upd_cnt, 0);
    chk("glitch_thermo", thermo, 4'b1111);
    chk("glitch_turbo", turbo, 0);

    // Illegal pattern.
    hold(8'h03, 10);
    upd_cnt = 0;
    hold(8'h05, 10);
    chk("ill_err", err, 1);
    chk("ill_thermo", thermo, 4'b0011);
    chk("ill_errcnt", errcnt, 1);
    chk("ill_upd_cnt", upd_cnt, 1);
    hold(8'h01, 10);
    chk("rec_err", err, 0);
    chk("rec_thermo", thermo, 4'b0001);

    // Saturation.
    for (int i = 0; i < 300; i++) hold((i % 2) ? 8'h09 : 8'h05, 10);
    chk("sat_errcnt", errcnt, 255);

    // Reset mid-filter with cnt at 3.
    hold(8'h00, 10);
    hold(8'h0F, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_thermo", thermo, 0);
    chk("mr_errcnt", errcnt, 0);
    chk("mr_err", err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mr_pre", thermo, 0);
    @(negedge clk);
    chk("mr_thermo_acc", thermo, 4'b1111);
    chk("mr_upd", upd, 1);

    // Randomized patterns, mostly legal, with random hold lengths.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] p;
      if ($urandom_range(0, 9) < 6) p = 8'((1 << $urandom_range(0, 8)) - 1);
      else p = 8'($urandom);
      hold(p, $urandom_range(1, 9));
    end
    hold(8'h00, 10);

    auto_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bgraph_encoder.md
# bgraph_encoder

Reverse-direction companion to the thermometer-to-bar-graph decoder: it takes an 8-segment bar-graph pattern from the front panel or sensor chain and recovers a 4-bit thermometer code plus a turbo (upper-half) flag. The raw pattern is synchronized and filtered so that it changes the outputs only after holding stable. Illegal (non-thermometer) patterns raise an error and increment a saturating counter. The block sits between the asynchronous bar-graph source and the control logic that consumes the Thermo/Turbo pair.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required to accept a pattern; legal range 2..255.
- Clk_in  input  1  single system clock, rising-edge.
- Reset_in  input  1  asynchronous, active-high reset.
- BGraph_in  input  8  raw bar-graph pattern, asynchronous to Clk_in; bit 0 is the lowest segment.
- Thermo_out  output  4  accepted thermometer code (LSB-filled).
- Turbo_out  output  1  1 when the accepted level is in the upper half (5..8 segments).
- Err_out  output  1  1 while the last accepted pattern was illegal.
- Upd_out  output  1  one-cycle pulse on every accepted change.
- ErrCnt_out  output  8  count of illegal patterns accepted, saturating at 255.

## Operation
- Synchronizer: two flops, sync1 then s. Both reset to 0x00.
- Stability filter, with candidate register cand (8b, reset 0x00) and counter cnt (reset 0), evaluated on each edge:
  - If s != cand: load cand <= s and cnt <= 1.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Else (cnt == STABLE_CYCLES-1 and s == cand): the pattern is accepted this edge.
  - cnt holds at STABLE_CYCLES-1 while the input stays stable.
- Committed register com (8b, reset 0x00) holds the last accepted pattern. An acceptance with cand == com is ignored: no pulse and no output change.
- Legality: a pattern is legal iff it equals 2^c-1 for c = 0..8, meaning the ones are contiguous from bit 0.
- Legal accept with c ones:
  - c in 0..4: Turbo_out=0, Thermo_out=(1<<c)-1.
  - c in 5..8: Turbo_out=1, Thermo_out=(1<<(c-4))-1.
  - Err_out=0; com<=cand; Upd_out=1 for one cycle.
- Illegal accept:
  - Thermo_out and Turbo_out hold their previous values.
  - Err_out=1; ErrCnt_out increments, saturating at 255.
  - com<=cand; Upd_out=1 for one cycle.
- Two-state view:
  - SETTLE: s != cand, or cnt < STABLE_CYCLES-1.
  - LOCKED: cnt == STABLE_CYCLES-1 and s == cand. The block stays here until s changes, then returns to SETTLE.
- Glitch rejection: any input held for fewer than STABLE_CYCLES synchronized cycles is never accepted, and com is unchanged.
- Returning to the previously committed pattern after a rejected glitch produces no Upd_out pulse.

## Timing
- Reset values: Thermo_out=0000, Turbo_out=0, Err_out=0, Upd_out=0, ErrCnt_out=0. All internal registers are cleared asynchronously on Reset_in=1.
- Latency: count the first rising edge that samples a new, steady BGraph_in as edge 1. The outputs and Upd_out change after edge STABLE_CYCLES+2 (edge 6 with the default).
- Upd_out is high for exactly one cycle per accepted change. Back-to-back acceptances are at least STABLE_CYCLES cycles apart.
- All outputs are registered; there is no combinational path from BGraph_in.
- Reset asserted mid-filter: everything clears immediately. After release, the current input needs the full STABLE_CYCLES+2 edges again.
- A steady all-zero input after reset never produces an Upd_out pulse, because com already equals 0x00.

## Test plan
- Reset, then BGraph_in=0x00 for 20 cycles -> all outputs 0, no Upd_out pulse.
- BGraph_in=0x07 steady -> after edge 6: Thermo_out=0111, Turbo_out=0, Err_out=0, Upd_out high for exactly 1 cycle. Then 0x3F -> Thermo_out=0011, Turbo_out=1. Then 0xFF -> Thermo_out=1111, Turbo_out=1.
- From committed 0x0F, pulse 0xFF for 2 cycles, then back to 0x0F -> no output change, no Upd_out pulse.
- BGraph_in=0x05 (illegal) steady, starting from committed 0x03 -> Err_out=1, Thermo_out stays 0011, ErrCnt_out=1, one Upd_out pulse. Then 0x01 -> Err_out=0, Thermo_out=0001.
- Alternate 0x05 and 0x09, each held 10 cycles, for 300 patterns -> ErrCnt_out saturates at 255 and never wraps.
- Assert Reset_in for 1 cycle at cnt=3 while 0x0F is pending -> immediate clear. After release, 0x0F is accepted on edge 6 counting from release.
